// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter/receiver state encoding
// and the parity helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_START = 3'd1,
    TX_DATA  = 3'd2,
    TX_PAR   = 3'd3,
    TX_STOP  = 3'd4
  } tx_state_t;

  // Unused upper bits of a narrow character are zero, so they do not disturb the XOR.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    return (^data) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with fall-through read data; full/empty derived from the
// occupancy count.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     rd,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             push;
  logic             pop;

  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign push  = wr && !full;
  assign pop   = rd && !empty;
  assign rdata = mem[rptr];

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: FIFO-fed, runtime baud divisor latched per
// frame, optional parity, one or two stop bits, sticky overflow flag.
//
//   state    | meaning
//   TX_IDLE  | line high, waiting for a queued character
//   TX_START | start bit (0)
//   TX_DATA  | DATA_BITS data bits, LSB first
//   TX_PAR   | parity bit (only when PARITY != PAR_NONE)
//   TX_STOP  | STOP_BITS stop bits (1), then next frame or idle
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic [DATA_BITS-1:0]          wdata,
  input  logic                          wr,
  input  logic                          clr_ovrflw,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          busy,
  output logic                          txd
);

  tx_state_t            state_q;
  tx_state_t            state_d;
  logic                 pop;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_nx;
  logic                 par_q;
  logic [DIV_W-1:0]     div_q;
  logic [DIV_W-1:0]     baud_cnt;
  logic [3:0]           bit_cnt;
  logic                 bit_done;
  logic                 last_data;
  logic                 last_stop;
  logic                 txd_q;
  logic                 txd_d;

  uart_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (wr),
    .wdata (wdata),
    .rd    (pop),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign bit_done  = (state_q != TX_IDLE) && (baud_cnt == '0);
  assign last_data = bit_done && (bit_cnt == 4'(DATA_BITS - 1));
  assign last_stop = bit_done && (bit_cnt == 4'(STOP_BITS - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= TX_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TX_IDLE:  if (!empty)  state_d = TX_START;
      TX_START: if (bit_done) state_d = TX_DATA;
      TX_DATA:  if (last_data) state_d = (PARITY != PAR_NONE) ? TX_PAR : TX_STOP;
      TX_PAR:   if (bit_done) state_d = TX_STOP;
      TX_STOP:  if (last_stop) state_d = empty ? TX_IDLE : TX_START;
      default:  state_d = TX_IDLE;
    endcase
  end

  // txd is registered, so its next value follows the next state and next shift contents.
  always_comb begin
    busy     = (state_q != TX_IDLE);
    pop      = !empty && ((state_q == TX_IDLE) || (state_q == TX_STOP && last_stop));
    shift_nx = shift_q;
    if (pop)                                shift_nx = fifo_rdata;
    else if (state_q == TX_DATA && bit_done) shift_nx = shift_q >> 1;
    txd_d = 1'b1;
    case (state_d)
      TX_START: txd_d = 1'b0;
      TX_DATA:  txd_d = shift_nx[0];
      TX_PAR:   txd_d = par_q;
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      txd_q    <= 1'b1;
      shift_q  <= '0;
      par_q    <= 1'b0;
      div_q    <= '0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      txd_q   <= txd_d;
      shift_q <= shift_nx;
      if (pop) begin
        div_q <= baud_div;
        par_q <= parity_bit(8'(fifo_rdata), PARITY);
      end
      // Down-counter reloaded at every bit boundary; the new frame's divisor is taken straight from the port.
      if (pop)                     baud_cnt <= baud_div;
      else if (bit_done)           baud_cnt <= div_q;
      else if (state_q != TX_IDLE) baud_cnt <= baud_cnt - 1'b1;
      if (pop || state_d != state_q) bit_cnt <= '0;
      else if (bit_done)             bit_cnt <= bit_cnt + 1'b1;
      if (wr && full)      overflow <= 1'b1;
      else if (clr_ovrflw) overflow <= 1'b0;
    end
  end

  assign txd = txd_q;

endmodule
